// File: rtl/lenet_pkg.sv
// Shared LeNet definitions: fully-connected layer input geometry and the
// state encoding used by the FC input packer.
package lenet_pkg;

  localparam int FC120_N      = 120;
  localparam int FC_ACT_WIDTH = 64;
  localparam int FC_CNT_WIDTH = $clog2(FC120_N);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fc_state_e;

endpackage : lenet_pkg

// File: rtl/fc_in_packer.sv
// Serial-to-parallel packer: collects N signed activations from a valid/ready
// stream into one flattened vector and holds it until the FC stage acks it.
module fc_in_packer
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH = FC_ACT_WIDTH,
  parameter int N          = FC120_N,
  parameter int CNT_WIDTH  = FC_CNT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  input  logic                         s_last,
  output logic [DATA_WIDTH*N-1:0]      vec_out,
  output logic                         vec_valid,
  input  logic                         vec_ack,
  output logic [CNT_WIDTH-1:0]         fill_count,
  output logic                         err_frame
);

  fc_state_e               r_state;
  fc_state_e               w_state_nxt;
  logic [CNT_WIDTH-1:0]    r_fill_count;
  logic [CNT_WIDTH-1:0]    w_fill_nxt;
  logic                    r_err;
  logic                    w_err_nxt;
  logic [DATA_WIDTH*N-1:0] r_vec;
  logic                    w_accept;
  logic                    w_at_end;

  // Gated by rst so upstream never sees a handshake while the block is resetting.
  assign s_ready  = (r_state == FILL) && !rst;
  assign w_accept = s_valid && s_ready;
  assign w_at_end = (r_fill_count == CNT_WIDTH'(N - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_fill_count <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fill_count <= w_fill_nxt;
      r_err        <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fill_nxt  = r_fill_count;
    w_err_nxt   = r_err;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          if (w_at_end) begin
            // Full vector is delivered even when the frame was not marked last.
            w_state_nxt = FULL;
            w_fill_nxt  = '0;
            if (!s_last) w_err_nxt = 1'b1;
          end else if (s_last) begin
            w_fill_nxt = '0;
            w_err_nxt  = 1'b1;
          end else begin
            w_fill_nxt = r_fill_count + CNT_WIDTH'(1);
          end
        end
      end
      FULL: begin
        if (vec_ack) w_state_nxt = FILL;
      end
      default: w_state_nxt = FILL;
    endcase
  end

  // One write-enabled register per slice; stale slices are left in place.
  for (genvar g = 0; g < N; g++) begin : g_slice
    always_ff @(posedge clk) begin
      if (rst) begin
        r_vec[g*DATA_WIDTH +: DATA_WIDTH] <= '0;
      end else if (w_accept && (r_fill_count == CNT_WIDTH'(g))) begin
        r_vec[g*DATA_WIDTH +: DATA_WIDTH] <= s_data;
      end
    end
  end

  assign vec_out    = r_vec;
  assign vec_valid  = (r_state == FULL);
  assign fill_count = r_fill_count;
  assign err_frame  = r_err;

endmodule : fc_in_packer

// File: tb/tb_fc_in_packer.sv
// Bench for fc_in_packer: directed frames, expected vectors queued at issue
// time and checked by an independent monitor when vec_valid rises.
module tb_fc_in_packer;
  localparam int DW = 64;
  localparam int NN = 120;
  localparam int CW = 7;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic signed [DW-1:0] s_data;
  logic                 s_last;
  logic [DW*NN-1:0]     vec_out;
  logic                 vec_valid;
  logic                 vec_ack;
  logic [CW-1:0]        fill_count;
  logic                 err_frame;

  int checks   = 0;
  int failures = 0;

  logic signed [DW-1:0] fd [NN];
  logic [DW*NN-1:0]     sb_q [$];
  logic                 prev_vv = 1'b0;

  fc_in_packer #(.DATA_WIDTH(DW), .N(NN), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .vec_out(vec_out),
    .vec_valid(vec_valid), .vec_ack(vec_ack), .fill_count(fill_count),
    .err_frame(err_frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW*NN-1:0] pack_fd();
    logic [DW*NN-1:0] v;
    for (int i = 0; i < NN; i++) v[i*DW +: DW] = fd[i];
    return v;
  endfunction

  // Scoreboard monitor: every rising vec_valid must match the oldest queued vector.
  always @(negedge clk) begin
    if (vec_valid && !prev_vv) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL vec_unexpected: vec_valid rose with no vector expected");
      end else begin
        logic [DW*NN-1:0] e;
        int bad;
        e   = sb_q.pop_front();
        bad = -1;
        for (int i = 0; i < NN; i++)
          if (bad < 0 && vec_out[i*DW +: DW] !== e[i*DW +: DW]) bad = i;
        if (bad >= 0) begin
          failures++;
          $display("FAIL vec_data: slice %0d got 0x%0h expected 0x%0h",
                   bad, vec_out[bad*DW +: DW], e[bad*DW +: DW]);
        end
      end
    end
    prev_vv = vec_valid;
  end

  task automatic send(input logic signed [DW-1:0] d, input logic l);
    logic acc;
    int   budget;
    budget  = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    do begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      budget++;
    end while (!acc && budget < 500);
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: beat not accepted in %0d cycles", budget);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int first, input int n, input bit mark_last, input bit gaps);
    for (int i = first; i < n; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      send(fd[i], mark_last && (i == n - 1));
    end
    if (n == NN) begin
      @(negedge clk);
      chk("vld_latency", {63'd0, vec_valid}, 64'd1);
    end
  endtask

  task automatic do_ack();
    int budget;
    budget = 0;
    while (!vec_valid && budget < 500) begin
      @(posedge clk);
      #1;
      budget++;
    end
    if (!vec_valid) chk("ack_wait", 64'd0, 64'd1);
    vec_ack = 1'b1;
    @(posedge clk);
    #1;
    vec_ack = 1'b0;
  endtask

  initial begin
    logic [DW*NN-1:0] held;
    int ready_seen;
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; vec_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_fill", 64'(fill_count), 64'd0);
    chk("rst_vld", {63'd0, vec_valid}, 64'd0);
    chk("rst_err", {63'd0, err_frame}, 64'd0);
    chk("rst_vec_zero", {63'd0, (vec_out == '0)}, 64'd1);
    @(posedge clk); #1;

    // Frame 1: back-to-back beats 1..120
    for (int i = 0; i < NN; i++) fd[i] = DW'(i + 1);
    sb_q.push_back(pack_fd());
    send_frame(0, NN, 1'b1, 1'b0);
    chk("f1_fill", 64'(fill_count), 64'd0);
    chk("f1_err", {63'd0, err_frame}, 64'd0);
    chk("f1_slice119", vec_out[119*DW +: DW], 64'd120);

    // Hold: upstream keeps offering data, nothing may be consumed
    held       = pack_fd();
    ready_seen = 0;
    s_valid    = 1'b1;
    s_data     = 64'hDEAD;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (s_ready) ready_seen++;
    end
    chk("hold_ready", 64'(ready_seen), 64'd0);
    chk("hold_vec_stable", {63'd0, (vec_out === held)}, 64'd1);
    chk("hold_vld", {63'd0, vec_valid}, 64'd1);

    // Frame 2 first beat offered during the ack cycle must wait one cycle
    for (int i = 0; i < NN; i++) fd[i] = -(i + 1);
    sb_q.push_back(pack_fd());
    s_data  = fd[0];
    vec_ack = 1'b1;
    @(posedge clk); #1;
    vec_ack = 1'b0;
    @(negedge clk);
    chk("ack_vld_low", {63'd0, vec_valid}, 64'd0);
    chk("ack_ready", {63'd0, s_ready}, 64'd1);
    chk("ack_no_consume", 64'(fill_count), 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    @(negedge clk);
    chk("slice0_after_ack", vec_out[DW-1:0], 64'hFFFF_FFFF_FFFF_FFFF);
    chk("fill_after_first", 64'(fill_count), 64'd1);
    @(posedge clk); #1;
    send_frame(1, NN, 1'b1, 1'b1);
    chk("f2_slice119", vec_out[119*DW +: DW], 64'hFFFF_FFFF_FFFF_FF88);
    do_ack();

    // Short frame: s_last on beat 49
    for (int i = 0; i < NN; i++) fd[i] = DW'(500 + i);
    send_frame(0, 50, 1'b1, 1'b0);
    @(negedge clk);
    chk("short_err", {63'd0, err_frame}, 64'd1);
    chk("short_fill", 64'(fill_count), 64'd0);
    chk("short_vld", {63'd0, vec_valid}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < NN; i++) fd[i] = DW'(1000 + i);
    sb_q.push_back(pack_fd());
    send_frame(0, NN, 1'b1, 1'b0);
    chk("clean_err_sticky", {63'd0, err_frame}, 64'd1);
    do_ack();

    // Long/unmarked frame after a fresh reset
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_err", {63'd0, err_frame}, 64'd0);
    @(posedge clk); #1;
    for (int i = 0; i < NN; i++) fd[i] = DW'(3 * i) ^ 64'h8000_0000_0000_0000;
    sb_q.push_back(pack_fd());
    send_frame(0, NN, 1'b0, 1'b1);
    chk("long_err", {63'd0, err_frame}, 64'd1);
    do_ack();

    // Reset in the middle of a fill
    for (int i = 0; i < NN; i++) fd[i] = DW'(77 + 5 * i);
    send_frame(0, 60, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid_fill60", 64'(fill_count), 64'd60);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", {63'd0, s_ready}, 64'd0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_fill", 64'(fill_count), 64'd0);
    chk("mid_rst_vec", {63'd0, (vec_out == '0)}, 64'd1);
    chk("mid_rst_vld", {63'd0, vec_valid}, 64'd0);
    @(posedge clk); #1;
    sb_q.push_back(pack_fd());
    send_frame(0, NN, 1'b1, 1'b0);
    chk("post_rst_err", {63'd0, err_frame}, 64'd0);
    do_ack();

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule : tb_fc_in_packer
